// File: rtl/unsc_decoder.sv
// Stochastic-bitstream window decoder: counts ones over 2^WINDOW_LOG2 enabled samples
// and presents the count (unipolar) or 2*ones-N (bipolar) behind a valid/ready handshake.
module unsc_decoder #(
    parameter int WINDOW_LOG2 = 8,
    parameter int BIPOLAR     = 0,
    parameter int CONTINUOUS  = 0
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iStart,
    input  logic                   iEn,
    input  logic                   iBit,
    input  logic                   iReady,
    output logic [WINDOW_LOG2+1:0] oData,
    output logic                   oValid,
    output logic                   oBusy,
    output logic                   oOvr
);
    localparam int OUT_W = WINDOW_LOG2 + 2;
    localparam int N     = 1 << WINDOW_LOG2;
    localparam logic [WINDOW_LOG2-1:0] LAST_IDX = {WINDOW_LOG2{1'b1}};
    localparam logic signed [OUT_W:0]  N_EXT    = (OUT_W+1)'(N);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t                  state, state_nxt;
    logic [WINDOW_LOG2-1:0]  samp_cnt, samp_cnt_nxt, samp_idx;
    logic [WINDOW_LOG2:0]    ones_cnt, ones_cnt_nxt, ones_sum;
    logic                    accept, win_end;
    logic signed [OUT_W-1:0] result_p0;
    logic signed [OUT_W-1:0] data_p1;
    logic                    vld_p1, ovr_p1;

    function automatic logic signed [OUT_W-1:0] to_unipolar(input logic [WINDOW_LOG2:0] ones);
        return $signed({1'b0, ones});
    endfunction

    // 2*ones - N always fits in OUT_W bits: range is -N..+N.
    function automatic logic signed [OUT_W-1:0] to_bipolar(input logic [WINDOW_LOG2:0] ones);
        logic signed [OUT_W:0] diff;
        diff = $signed({1'b0, ones, 1'b0}) - N_EXT;
        return $signed(diff[OUT_W-1:0]);
    endfunction

    // Stage p0: window counting; a start cycle is itself sample 0.
    always_comb begin
        state_nxt    = state;
        samp_cnt_nxt = samp_cnt;
        ones_cnt_nxt = ones_cnt;
        samp_idx     = iStart ? '0 : samp_cnt;
        ones_sum     = (iStart ? '0 : ones_cnt) + {{WINDOW_LOG2{1'b0}}, iBit};
        accept       = iEn && (iStart || (state == COUNT));
        win_end      = accept && (samp_idx == LAST_IDX);
        result_p0    = (BIPOLAR != 0) ? to_bipolar(ones_sum) : to_unipolar(ones_sum);

        if (iStart) begin
            state_nxt    = COUNT;
            samp_cnt_nxt = '0;
            ones_cnt_nxt = '0;
        end
        if (accept) begin
            samp_cnt_nxt = samp_idx + 1'b1;
            ones_cnt_nxt = ones_sum;
        end
        if (win_end) begin
            samp_cnt_nxt = '0;
            ones_cnt_nxt = '0;
            state_nxt    = (CONTINUOUS != 0) ? COUNT : IDLE;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= IDLE;
            samp_cnt <= '0;
            ones_cnt <= '0;
        end else begin
            state    <= state_nxt;
            samp_cnt <= samp_cnt_nxt;
            ones_cnt <= ones_cnt_nxt;
        end
    end

    // Stage p1: result register; a new result wins over a same-cycle handshake.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            ovr_p1  <= 1'b0;
        end else if (win_end) begin
            data_p1 <= result_p0;
            vld_p1  <= 1'b1;
            if (vld_p1 && !iReady)
                ovr_p1 <= 1'b1;
        end else if (vld_p1 && iReady) begin
            vld_p1 <= 1'b0;
        end
    end

    assign oData  = data_p1;
    assign oValid = vld_p1;
    assign oBusy  = (state == COUNT);
    assign oOvr   = ovr_p1;
endmodule

// File: doc/unsc_decoder.md
UNSC_DECODER -- requirements
Module: unsc_decoder

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 8, meaning window length N = 2^WINDOW_LOG2 samples.
REQ-002 SHALL have parameter BIPOLAR, default 0, meaning 0 = unipolar count output and 1 = bipolar signed output.
REQ-003 SHALL have parameter CONTINUOUS, default 0, meaning 1 = start the next window automatically with no idle gap.
REQ-004 SHALL have port iClk, input, 1 bit, the single clock; all logic rises on its posedge.
REQ-005 SHALL have port iRst, input, 1 bit; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port iStart, input, 1 bit, which begins or restarts a window.
REQ-007 SHALL have port iEn, input, 1 bit, which marks iBit as a valid stochastic sample this cycle.
REQ-008 SHALL have port iBit, input, 1 bit, the stochastic bitstream sample.
REQ-009 SHALL have port iReady, input, 1 bit, the consumer's acceptance of oData.
REQ-010 SHALL have port oData, output, WINDOW_LOG2+2 bits, the decoded window result.
REQ-011 SHALL have port oValid, output, 1 bit, which is high while oData holds an unconsumed result.
REQ-012 SHALL have port oBusy, output, 1 bit, which is high while a window is being counted.
REQ-013 SHALL have port oOvr, output, 1 bit, a sticky flag indicating an unconsumed result was overwritten.

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and COUNT; oBusy = (state == COUNT).
REQ-015 SHALL, in IDLE with iStart=1, move to COUNT and clear the sample counter and the ones counter.
REQ-016 SHALL treat the iStart cycle as sample 0, counted if iEn=1.
REQ-017 SHALL, in COUNT with iStart=1, restart the window: discard partial counts and treat the current cycle as sample 0; no result is produced.
REQ-018 SHALL, in COUNT with iEn=1, increment the sample counter and add iBit to the ones counter; iEn=0 cycles change neither counter.
REQ-019 SHALL size the ones counter at WINDOW_LOG2+1 bits so that all-ones (N) cannot wrap.
REQ-020 SHALL treat the cycle accepting sample N-1 as the window end.
REQ-021 SHALL, at window end, load the final count into the output register, set oValid on the next cycle, and clear both counters.
REQ-022 SHALL, at window end, go to IDLE when CONTINUOUS=0, or stay in COUNT with the next enabled sample as sample 0 when CONTINUOUS=1.
REQ-023 SHALL produce oData in unipolar mode as the ones count zero-extended: range 0..N.
REQ-024 SHALL produce oData in bipolar mode as the two's complement value 2*ones - N: range -N..+N.
REQ-025 SHALL clear oValid on the first cycle after oValid=1 and iReady=1 are sampled high together.
REQ-026 SHALL keep oData stable while oValid=1 and no new window ends.
REQ-027 SHALL, when a window ends while oValid=1 and iReady=0, overwrite oData with the new result, keep oValid=1, and set oOvr=1.
REQ-028 SHALL, when a window ends in the same cycle as a handshake, load the new result with no overflow: oValid stays 1 and oOvr is unchanged.
REQ-029 SHALL clear oOvr only by reset.
REQ-030 SHALL have a latency of 1 cycle from the window-end sample edge to oValid/oData.
REQ-031 SHALL ignore iBit when iEn=0 and ignore iBit in IDLE unless iStart=1.

Reset
REQ-032 SHALL, when iRst=1 at a posedge, force state IDLE, clear both counters, and set oData=0, oValid=0, oBusy=0, oOvr=0.
REQ-033 SHALL give iRst priority over iStart, iEn and the handshake in the same cycle.
REQ-034 SHALL, on reset mid-window, discard the partial window; the next iStart begins a fresh window.

Verification
REQ-035 SHALL cover: WINDOW_LOG2=8, unipolar, iStart then 256 enabled ones -> oValid=1 one cycle after sample 255, oData=256, oBusy=0.
REQ-036 SHALL cover: bipolar, 256 samples alternating 1/0 -> oData=0; all zeros -> oData=-256 (10'h300).
REQ-037 SHALL cover: unipolar, 64 ones then 192 zeros, each separated by an iEn=0 cycle carrying iBit=1 -> oData=64, window end at the 256th enabled sample.
REQ-038 SHALL cover: CONTINUOUS=1, iReady=0, two back-to-back windows (128 ones, then 32 ones) -> oData=32, oValid=1, oOvr=1; then iReady=1 for one cycle -> oValid=0.
REQ-039 SHALL cover: iRst=1 after sample 100 -> all outputs 0 next cycle; a new iStart plus 256 ones -> oData=256.
REQ-040 SHALL cover: iStart reasserted at sample 200 of a window, then 256 ones -> exactly one result, oData=256, oOvr=0.
